// File: rtl/pc_redirect_if.sv
// Fetch-stage PC redirect bus between the ID-side controller (master) and pc_redirect_unit (slave).
// EXC_REDIRECT_EN adds the exception request and EPC signals.
interface pc_redirect_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   stall;
  logic                   branch_taken;
  logic [31:0]            branch_offset_shifted;
  logic [31:0]            branch_base_pc;
  logic                   jump_en;
  logic [25:0]            jump_index;
  logic [31:0]            pc;
  logic [31:0]            pc_plus4;
  logic [31:0]            ifid_pc_plus4;
  logic                   ifid_valid;
  logic                   redirect;
  logic [STALL_CNT_W-1:0] stall_cycles;
`ifdef EXC_REDIRECT_EN
  logic                   exc_req;
  logic [31:0]            epc;

  modport master (
    output stall, branch_taken, branch_offset_shifted, branch_base_pc,
           jump_en, jump_index, exc_req,
    input  pc, pc_plus4, ifid_pc_plus4, ifid_valid, redirect, stall_cycles, epc
  );
  modport slave (
    input  stall, branch_taken, branch_offset_shifted, branch_base_pc,
           jump_en, jump_index, exc_req,
    output pc, pc_plus4, ifid_pc_plus4, ifid_valid, redirect, stall_cycles, epc
  );
`else
  modport master (
    output stall, branch_taken, branch_offset_shifted, branch_base_pc,
           jump_en, jump_index,
    input  pc, pc_plus4, ifid_pc_plus4, ifid_valid, redirect, stall_cycles
  );
  modport slave (
    input  stall, branch_taken, branch_offset_shifted, branch_base_pc,
           jump_en, jump_index,
    output pc, pc_plus4, ifid_pc_plus4, ifid_valid, redirect, stall_cycles
  );
`endif
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register and next-PC selector with IF/ID PC+4 latch, stall and flush control.
// Optional macro EXC_REDIRECT_EN adds an exception redirect to EXC_VECTOR and an EPC register.
//
// state | meaning
// RUN   | normal fetch, IF/ID advances every cycle
// HOLD  | ID hazard stall, PC and IF/ID frozen
// FLUSH | one cycle after a redirect, IF/ID holds a bubble
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
`ifdef EXC_REDIRECT_EN
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080,
`endif
  parameter int          STALL_CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  pc_redirect_if.slave bus
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_sel, pc_d;
  logic [31:0]            ifid_q, ifid_d;
  logic                   valid_q, valid_d;
  logic                   redirect_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [31:0]            pc_plus4;
  logic [31:0]            branch_tgt, jump_tgt, redir_tgt;
  logic                   redir_ev;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = bus.branch_base_pc + bus.branch_offset_shifted;
  assign jump_tgt   = {bus.branch_base_pc[31:28], bus.jump_index, 2'b00};

`ifdef EXC_REDIRECT_EN
  logic [31:0] epc_q;

  assign redir_ev  = bus.exc_req | bus.jump_en | bus.branch_taken;
  assign redir_tgt = bus.exc_req ? EXC_VECTOR :
                     bus.jump_en ? jump_tgt   : branch_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q <= 32'h0;
    end else if (bus.exc_req) begin
      epc_q <= bus.branch_base_pc - 32'd4;
    end
  end

  assign bus.epc = epc_q;
`else
  assign redir_ev  = bus.jump_en | bus.branch_taken;
  assign redir_tgt = bus.jump_en ? jump_tgt : branch_tgt;
`endif

  always_comb begin
    state_d = state_q;
    pc_sel  = pc_plus4;
    ifid_d  = ifid_q;
    valid_d = valid_q;
    case (state_q)
      RUN, HOLD: begin
        if (redir_ev) begin
          state_d = FLUSH;
          pc_sel  = redir_tgt;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          state_d = HOLD;
          pc_sel  = pc_q;
        end else begin
          state_d = RUN;
          ifid_d  = pc_plus4;
          valid_d = 1'b1;
        end
      end
      FLUSH: begin
        // ID holds a bubble here, so a stall request has nothing to protect
        if (redir_ev) begin
          state_d = FLUSH;
          pc_sel  = redir_tgt;
          valid_d = 1'b0;
        end else begin
          state_d = RUN;
          ifid_d  = pc_plus4;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign pc_d = pc_sel & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ifid_q     <= 32'h0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      valid_q    <= valid_d;
      redirect_q <= (state_d == FLUSH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bus.stall && !redir_ev && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.ifid_pc_plus4 = ifid_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.redirect      = redirect_q;
  assign bus.stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed steps push expected post-edge state, a monitor pops and compares.
module tb_pc_redirect_unit;

  localparam int SCW = 16;

  typedef struct {
    logic [31:0]    pc;
    logic [31:0]    ifid;
    logic           v;
    logic           red;
    logic [SCW-1:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pc_redirect_if #(.STALL_CNT_W(SCW)) bus ();

  pc_redirect_unit #(
    .RESET_PC    (32'h0000_0000),
    .STALL_CNT_W (SCW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic st, input logic br, input logic [31:0] off,
                      input logic [31:0] base, input logic jp, input logic [25:0] ji,
                      input logic [31:0] e_pc, input logic [31:0] e_ifid,
                      input logic e_v, input logic e_red, input logic [SCW-1:0] e_sc);
    exp_t e;
    bus.stall                 = st;
    bus.branch_taken          = br;
    bus.branch_offset_shifted = off;
    bus.branch_base_pc        = base;
    bus.jump_en               = jp;
    bus.jump_index            = ji;
    e.pc = e_pc; e.ifid = e_ifid; e.v = e_v; e.red = e_red; e.sc = e_sc;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic [31:0] e_ifid, input logic [SCW-1:0] e_sc);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, e_pc, e_ifid, 1'b1, 1'b0, e_sc);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"},         bus.pc, 32'h0);
    chk({tag, ".ifid_pc4"},   bus.ifid_pc_plus4, 32'h0);
    chk({tag, ".ifid_valid"}, {31'b0, bus.ifid_valid}, 32'h0);
    chk({tag, ".redirect"},   {31'b0, bus.redirect}, 32'h0);
    chk({tag, ".stall_cyc"},  {16'b0, bus.stall_cycles}, 32'h0);
`ifdef EXC_REDIRECT_EN
    chk({tag, ".epc"},        bus.epc, 32'h0);
`endif
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("pc",         bus.pc, mon_e.pc);
      chk("pc_plus4",   bus.pc_plus4, mon_e.pc + 32'd4);
      chk("ifid_pc4",   bus.ifid_pc_plus4, mon_e.ifid);
      chk("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, mon_e.v});
      chk("redirect",   {31'b0, bus.redirect}, {31'b0, mon_e.red});
      chk("stall_cyc",  {16'b0, bus.stall_cycles}, {16'b0, mon_e.sc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump_en = 1'b0;
    bus.branch_offset_shifted = 32'h0; bus.branch_base_pc = 32'h0; bus.jump_index = 26'h0;
`ifdef EXC_REDIRECT_EN
    bus.exc_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // sequential fetch
    idle(32'h4,  32'h4,  0);
    idle(32'h8,  32'h8,  0);
    idle(32'hC,  32'hC,  0);
    idle(32'h10, 32'h10, 0);
    // backward branch
    step(0, 1, 32'hFFFF_FFF0, 32'h100, 0, 26'h0, 32'hF0, 32'h10, 0, 1, 0);
    idle(32'hF4, 32'hF4, 0);
    // jump beats branch
    step(0, 1, 32'h1000, 32'h4000_0010, 1, 26'h40, 32'h4000_0100, 32'hF4, 0, 1, 0);
    idle(32'h4000_0104, 32'h4000_0104, 0);
    step(0, 0, 32'h0, 32'h10, 1, 26'h7, 32'h1C, 32'h4000_0104, 0, 1, 0);
    idle(32'h20, 32'h20, 0);
    // five stall cycles at 0x20
    for (int i = 1; i <= 5; i++)
      step(1, 0, 32'h0, 32'h0, 0, 26'h0, 32'h20, 32'h20, 1, 0, SCW'(i));
    idle(32'h24, 32'h24, 5);
    // redirect beats stall; stall in FLUSH ignored but counted
    step(1, 1, 32'h8, 32'h8, 0, 26'h0, 32'h10, 32'h24, 0, 1, 5);
    step(1, 0, 32'h0, 32'h0, 0, 26'h0, 32'h14, 32'h14, 1, 0, 6);
    idle(32'h18, 32'h18, 6);
    // back-to-back redirects keep FLUSH
    step(0, 1, 32'h10, 32'h200, 0, 26'h0, 32'h210, 32'h18, 0, 1, 6);
    step(0, 1, 32'h0,  32'h300, 0, 26'h0, 32'h300, 32'h18, 0, 1, 6);
    idle(32'h304, 32'h304, 6);
    // PC+4 and branch-target wrap
    step(0, 0, 32'h0, 32'hF000_0000, 1, 26'h3FF_FFFF, 32'hFFFF_FFFC, 32'h304, 0, 1, 6);
    idle(32'h0, 32'h0, 6);
    step(0, 1, 32'h20, 32'hFFFF_FFF0, 0, 26'h0, 32'h10, 32'h0, 0, 1, 6);
    idle(32'h14, 32'h14, 6);
    // redirect out of HOLD
    step(1, 0, 32'h0, 32'h0, 0, 26'h0, 32'h14, 32'h14, 1, 0, 7);
    step(1, 0, 32'h0, 32'h0, 1, 26'h10, 32'h40, 32'h14, 0, 1, 7);
    idle(32'h44, 32'h44, 7);
    // async reset while in FLUSH
    step(0, 1, 32'h0, 32'h500, 0, 26'h0, 32'h500, 32'h44, 0, 1, 7);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    #1 rst_n = 1'b1;
    idle(32'h4, 32'h4, 0);
    // unaligned target gets its low bits cleared
    step(0, 1, 32'h6, 32'h100, 0, 26'h0, 32'h104, 32'h4, 0, 1, 0);
    idle(32'h108, 32'h108, 0);
`ifdef EXC_REDIRECT_EN
    bus.exc_req = 1'b1;
    step(0, 1, 32'h40, 32'h54, 1, 26'h1, 32'h80, 32'h108, 0, 1, 0);
    bus.exc_req = 1'b0;
    chk("epc", bus.epc, 32'h50);
    idle(32'h84, 32'h84, 0);
    chk("epc_hold", bus.epc, 32'h50);
`endif
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
